dircc_receive_handler_nport: RTL and testbench

DIRCC_RECEIVE_HANDLER_NPORT -- requirements
Module: dircc_receive_handler_nport

---
 rtl/dircc_receive_handler_nport.sv | 199 +++++++++++++++++++
 tb/tb_dircc_receive_handler_nport.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dircc_receive_handler_nport.sv
// Multi-port timestep receive handler: per-port FIFOs, round-robin pop,
// and saturating weighted accumulation for the current and next timestep.
module dircc_receive_handler_nport #(
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIME_W     = 16,
   parameter int DATA_W     = 16,
   parameter int WEIGHT_W   = 16,
   parameter int ACC_W      = 32,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [CNT_W-1:0]              neighbour_count,
   input  logic [TIME_W-1:0]             max_time,
   input  logic [NUM_PORTS-1:0]          in_valid,
   output logic [NUM_PORTS-1:0]          in_ready,
   input  logic [NUM_PORTS*TIME_W-1:0]   in_t,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_temp,
   input  logic [NUM_PORTS*WEIGHT_W-1:0] in_weight,
   output logic [TIME_W-1:0]             cur_t,
   output logic signed [ACC_W-1:0]       acc_now,
   output logic signed [ACC_W-1:0]       acc_next,
   output logic [CNT_W-1:0]              seen_now,
   output logic [CNT_W-1:0]              seen_next,
   output logic                          step,
   output logic                          done,
   output logic                          sat,
   output logic [CNT_W-1:0]              err_count
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PROD_W = DATA_W + WEIGHT_W;
   localparam int PKT_W  = TIME_W + DATA_W + WEIGHT_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                         state;
   logic [PW-1:0]                      rr_ptr;
   logic [NUM_PORTS-1:0]               empty;
   logic [NUM_PORTS-1:0]               push;
   logic [NUM_PORTS-1:0]               pop;
   logic [NUM_PORTS-1:0][PKT_W-1:0]    head;

   logic                               grant_vld;
   logic [PW-1:0]                      grant;
   logic [PW-1:0]                      grant_nxt;
   int                                 arb_idx;
   logic                               roll_cond;
   logic                               pop_en;

   logic [PKT_W-1:0]                   pkt;
   logic [TIME_W-1:0]                  p_t;
   logic signed [DATA_W-1:0]           p_temp;
   logic signed [WEIGHT_W-1:0]         p_w;
   logic signed [PROD_W-1:0]           prod;
   logic [ACC_W-1:0]                   prod_ext;
   logic [ACC_W:0]                     add_now;
   logic [ACC_W:0]                     add_next;
   logic [TIME_W-1:0]                  t_next;

   // Per-port FIFO: extra pointer bit separates full from empty.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
      logic [PKT_W-1:0] mem [FIFO_DEPTH];
      logic [AW:0]      wr_ptr;
      logic [AW:0]      rd_ptr;
      logic             full;

      assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign empty[p]    = (wr_ptr == rd_ptr);
      assign in_ready[p] = ~full;
      assign push[p]     = in_valid[p] & ~full;
      assign head[p]     = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk) begin
         if (push[p])
            mem[wr_ptr[AW-1:0]] <= {in_t[p*TIME_W +: TIME_W],
                                    in_temp[p*DATA_W +: DATA_W],
                                    in_weight[p*WEIGHT_W +: WEIGHT_W]};
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push[p]) wr_ptr <= wr_ptr + 1'b1;
            if (pop[p])  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      arb_idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         arb_idx = (int'(rr_ptr) + i) % NUM_PORTS;
         if (!grant_vld && !empty[arb_idx]) begin
            grant_vld = 1'b1;
            grant     = PW'(arb_idx);
         end
      end
   end

   assign grant_nxt = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
   assign roll_cond = (seen_now == neighbour_count);

   assign pop_en = grant_vld && !start &&
                   ((state == S_DONE) ||
                    (state == S_RUN && !roll_cond));

   always_comb begin
      pop = '0;
      if (pop_en) pop[grant] = 1'b1;
   end

   assign pkt      = head[grant];
   assign p_t      = pkt[PKT_W-1 -: TIME_W];
   assign p_temp   = pkt[PROD_W-1 -: DATA_W];
   assign p_w      = pkt[WEIGHT_W-1:0];
   assign prod     = p_temp * p_w;
   assign prod_ext = ACC_W'(prod);
   assign t_next   = cur_t + 1'b1;

   // Result is {overflowed, clamped sum}.
   function automatic logic [ACC_W:0] sat_add(
      input logic [ACC_W-1:0] a,
      input logic [ACC_W-1:0] b
   );
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1])
         sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
      else
         sat_add = {1'b0, s[ACC_W-1:0]};
   endfunction

   assign add_now  = sat_add(acc_now, prod_ext);
   assign add_next = sat_add(acc_next, prod_ext);
   assign done     = (state == S_DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         cur_t     <= '0;
         acc_now   <= '0;
         acc_next  <= '0;
         seen_now  <= '0;
         seen_next <= '0;
         step      <= 1'b0;
         sat       <= 1'b0;
         err_count <= '0;
      end else begin
         step <= 1'b0;
         if (start) begin
            state     <= S_RUN;
            cur_t     <= '0;
            acc_now   <= '0;
            acc_next  <= '0;
            seen_now  <= '0;
            seen_next <= '0;
            sat       <= 1'b0;
            err_count <= '0;
         end else if (state == S_RUN && roll_cond) begin
            if (cur_t == max_time) begin
               state <= S_DONE;
            end else begin
               cur_t     <= t_next;
               acc_now   <= acc_next;
               seen_now  <= seen_next;
               acc_next  <= '0;
               seen_next <= '0;
               step      <= 1'b1;
            end
         end else if (pop_en) begin
            rr_ptr <= grant_nxt;
            if (state == S_RUN && p_t == cur_t) begin
               acc_now <= add_now[ACC_W-1:0];
               if (add_now[ACC_W]) sat <= 1'b1;
               if (seen_now != '1) seen_now <= seen_now + 1'b1;
            end else if (state == S_RUN && p_t == t_next) begin
               acc_next <= add_next[ACC_W-1:0];
               if (add_next[ACC_W]) sat <= 1'b1;
               if (seen_next != '1) seen_next <= seen_next + 1'b1;
            end else if (err_count != '1) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dircc_receive_handler_nport.sv
// Randomized bench for dircc_receive_handler_nport against a
// queue-based timestep model.
module tb_dircc_receive_handler_nport;

   localparam int NP = 4;
   localparam int DEPTH = 4;
   localparam longint AMAX = 64'sd2147483647;
   localparam longint AMIN = -64'sd2147483648;

   typedef struct packed {
      logic [15:0]        t;
      logic signed [15:0] temp;
      logic signed [15:0] w;
   } pkt_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic [7:0]         neighbour_count = '0;
   logic [15:0]        max_time = '0;
   logic [NP-1:0]      in_valid = '0;
   logic [NP-1:0]      in_ready;
   logic [NP*16-1:0]   in_t = '0;
   logic [NP*16-1:0]   in_temp = '0;
   logic [NP*16-1:0]   in_weight = '0;
   logic [15:0]        cur_t;
   logic signed [31:0] acc_now;
   logic signed [31:0] acc_next;
   logic [7:0]         seen_now;
   logic [7:0]         seen_next;
   logic               step;
   logic               done;
   logic               sat;
   logic [7:0]         err_count;

   int errors = 0;
   int checks = 0;

   pkt_t   q [NP][$];
   int     m_st;
   int     m_ptr;
   int     m_t;
   longint m_acc_now;
   longint m_acc_next;
   int     m_seen_now;
   int     m_seen_next;
   int     m_err;
   bit     m_sat;
   bit     m_step;

   dircc_receive_handler_nport #(
      .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .TIME_W(16), .DATA_W(16),
      .WEIGHT_W(16), .ACC_W(32), .CNT_W(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .neighbour_count(neighbour_count), .max_time(max_time),
      .in_valid(in_valid), .in_ready(in_ready), .in_t(in_t),
      .in_temp(in_temp), .in_weight(in_weight), .cur_t(cur_t),
      .acc_now(acc_now), .acc_next(acc_next), .seen_now(seen_now),
      .seen_next(seen_next), .step(step), .done(done), .sat(sat),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sadd(input longint a, input longint b);
      longint v;
      v = a + b;
      if (v > AMAX) begin v = AMAX; m_sat = 1'b1; end
      if (v < AMIN) begin v = AMIN; m_sat = 1'b1; end
      return v;
   endfunction

   task automatic model_clear();
      m_t = 0; m_acc_now = 0; m_acc_next = 0;
      m_seen_now = 0; m_seen_next = 0; m_err = 0; m_sat = 1'b0;
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) q[p].delete();
      m_st = 0; m_ptr = 0; m_step = 1'b0;
      model_clear();
   endtask

   // One rising edge of the reference: decide, pop, then accept pushes.
   task automatic model_step();
      bit     rdy [NP];
      int     g;
      pkt_t   pk;
      longint pr;
      for (int p = 0; p < NP; p++) rdy[p] = q[p].size() < DEPTH;
      m_step = 1'b0;
      g = -1;
      if (start) begin
         m_st = 1;
         model_clear();
      end else if (m_st == 1 && m_seen_now == int'(neighbour_count)) begin
         if (m_t == int'(max_time)) m_st = 2;
         else begin
            m_t = (m_t + 1) % 65536;
            m_acc_now = m_acc_next; m_seen_now = m_seen_next;
            m_acc_next = 0; m_seen_next = 0; m_step = 1'b1;
         end
      end else if (m_st != 0) begin
         for (int i = 0; i < NP; i++)
            if (g < 0 && q[(m_ptr + i) % NP].size() > 0) g = (m_ptr + i) % NP;
         if (g >= 0) begin
            pk = q[g].pop_front();
            m_ptr = (g + 1) % NP;
            pr = longint'(pk.temp) * longint'(pk.w);
            if (m_st == 1 && int'(pk.t) == m_t) begin
               m_acc_now = sadd(m_acc_now, pr);
               if (m_seen_now < 255) m_seen_now++;
            end else if (m_st == 1 && int'(pk.t) == (m_t + 1) % 65536) begin
               m_acc_next = sadd(m_acc_next, pr);
               if (m_seen_next < 255) m_seen_next++;
            end else if (m_err < 255) m_err++;
         end
      end
      for (int p = 0; p < NP; p++)
         if (in_valid[p] && rdy[p])
            q[p].push_back({in_t[p*16 +: 16], in_temp[p*16 +: 16],
                            in_weight[p*16 +: 16]});
   endtask

   task automatic check_all();
      chk("cur_t", longint'(cur_t), longint'(m_t));
      chk("acc_now", longint'(acc_now), m_acc_now);
      chk("acc_next", longint'(acc_next), m_acc_next);
      chk("seen_now", longint'(seen_now), longint'(m_seen_now));
      chk("seen_next", longint'(seen_next), longint'(m_seen_next));
      chk("step", longint'(step), longint'(m_step));
      chk("done", longint'(done), longint'(m_st == 2));
      chk("sat", longint'(sat), longint'(m_sat));
      chk("err_count", longint'(err_count), longint'(m_err));
      for (int p = 0; p < NP; p++)
         chk("in_ready", longint'(in_ready[p]), longint'(q[p].size() < DEPTH));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      start = 1'b0;
      in_valid = '0;
   endtask

   task automatic do_reset();
      start = 1'b0;
      in_valid = '0;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;
   endtask

   task automatic set_pkt(input int p, input logic [15:0] t,
                          input logic [15:0] temp, input logic [15:0] w);
      in_valid[p] = 1'b1;
      in_t[p*16 +: 16] = t;
      in_temp[p*16 +: 16] = temp;
      in_weight[p*16 +: 16] = w;
   endtask

   task automatic rand_pkt(input int p);
      logic [15:0] t, temp, w;
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) t = 16'(m_t);
      else if (r < 8) t = 16'(m_t + 1);
      else t = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
         temp = 16'($urandom); w = 16'($urandom);
      end else begin
         temp = 16'($urandom_range(0, 20) - 10);
         w = 16'($urandom_range(0, 20) - 10);
      end
      set_pkt(p, t, temp, w);
   endtask

   initial begin
      #2;
      model_reset();
      check_all();
      do_reset();

      // Two-packet timestep then roll
      neighbour_count = 8'd2; max_time = 16'd1; start = 1'b1; tick();
      set_pkt(0, 16'd0, 16'd3, 16'd2); tick();
      set_pkt(1, 16'd0, 16'd5, 16'd1); tick();
      tick();
      chk("r32_acc", longint'(acc_now), 11);
      tick();
      chk("r32_step", longint'(step), 1);
      chk("r32_cur_t", longint'(cur_t), 1);
      chk("r32_acc0", longint'(acc_now), 0);

      // Round-robin order revealed by distinct payloads
      do_reset();
      neighbour_count = 8'd4; max_time = 16'd5; start = 1'b1; tick();
      set_pkt(0, 16'd0, 16'd1, 16'd1);
      set_pkt(1, 16'd0, 16'd10, 16'd1);
      set_pkt(2, 16'd0, 16'd100, 16'd1);
      set_pkt(3, 16'd0, 16'd1000, 16'd1);
      tick();
      tick(); chk("r33_g0", longint'(acc_now), 1);
      tick(); chk("r33_g1", longint'(acc_now), 11);
      tick(); chk("r33_g2", longint'(acc_now), 111);
      tick(); chk("r33_g3", longint'(acc_now), 1111);
      chk("r33_seen", longint'(seen_now), 4);

      // Back-pressure on port 2 while idle
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_pkt(2, 16'd0, 16'(i), 16'd1);
         tick();
         if (i == 3) chk("r34_full", longint'(in_ready[2]), 0);
      end
      neighbour_count = 8'd8; max_time = 16'd3; start = 1'b1; tick();
      chk("r34_start_nopop", longint'(in_ready[2]), 0);
      tick();
      chk("r34_after_pop", longint'(in_ready[2]), 1);

      // Next-timestep packet, roll, then an out-of-window packet
      do_reset();
      neighbour_count = 8'd1; max_time = 16'd9; start = 1'b1; tick();
      set_pkt(0, 16'd1, -16'sd4, 16'd3);
      set_pkt(1, 16'd0, 16'd0, 16'd0);
      tick();
      tick();
      tick();
      tick();
      chk("r35_acc", longint'(acc_now), -12);
      chk("r35_seen", longint'(seen_now), 1);
      chk("r35_t", longint'(cur_t), 1);
      set_pkt(2, 16'd6, 16'd1, 16'd1); tick();
      tick();
      chk("r35_err", longint'(err_count), 1);

      // Positive saturation, then asynchronous reset mid-run
      do_reset();
      neighbour_count = 8'd8; max_time = 16'd3; start = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         set_pkt(0, 16'd0, 16'd32767, 16'd32767); tick();
      end
      tick();
      chk("r36_acc", longint'(acc_now), AMAX);
      chk("r36_sat", longint'(sat), 1);
      set_pkt(1, 16'd0, 16'd1, 16'd1); tick();
      do_reset();
      chk("r36_rdy", longint'(in_ready), 15);

      // Randomized traffic with occasional restarts and resets
      for (int c = 0; c < 1500; c++) begin
         if (c % 200 == 0 || (m_st != 1 && $urandom_range(0, 15) == 0)) begin
            neighbour_count = 8'($urandom_range(0, 4));
            max_time = 16'($urandom_range(0, 4));
            start = 1'b1;
         end
         for (int p = 0; p < NP; p++)
            if ($urandom_range(0, 1) == 1) rand_pkt(p);
         if ($urandom_range(0, 499) == 0) do_reset();
         else tick();
      end

      // Long DONE phase drives err_count into saturation
      neighbour_count = 8'd0; max_time = 16'd0; start = 1'b1; tick();
      for (int c = 0; c < 300; c++) begin
         for (int p = 0; p < NP; p++) rand_pkt(p);
         tick();
      end
      chk("done_hold", longint'(done), 1);
      chk("err_sat", longint'(err_count), 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
